// File: rtl/switch_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_pkg
// Description : Shared per-bit FSM state type and default sizing constants
//               for the switch debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_debounce_pkg;

    localparam int c_WIDTH_DEFAULT           = 8;
    localparam int c_DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int c_SYNC_STAGES_DEFAULT     = 2;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_t;

endpackage : switch_debounce_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : Single-bit debouncer: synchronizer chain, stability counter
//               and STABLE/PENDING FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = c_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_clean,
    output logic o_update
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    db_state_t              r_state;
    logic                   r_clean;
    logic                   w_sync;
    logic                   w_differs;
    logic                   w_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_sync != r_clean);

    // The counter holds the number of mismatching cycles already seen, so the
    // current cycle completes the run when it reads DEBOUNCE_CYCLES-1.
    always_comb begin
        w_expire = 1'b0;
        if (w_differs) begin
            if (r_state == STABLE) begin
                w_expire = (DEBOUNCE_CYCLES == 1);
            end else begin
                w_expire = (r_cnt == c_CNT_LAST);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STABLE;
            r_cnt   <= c_CNT_ZERO;
            r_clean <= 1'b0;
        end else begin
            case (r_state)
                STABLE: begin
                    if (w_differs) begin
                        if (w_expire) begin
                            r_clean <= w_sync;
                        end else begin
                            r_state <= PENDING;
                            r_cnt   <= c_CNT_ONE;
                        end
                    end
                end
                PENDING: begin
                    if (!w_differs) begin
                        r_state <= STABLE;
                        r_cnt   <= c_CNT_ZERO;
                    end else if (w_expire) begin
                        r_clean <= w_sync;
                        r_state <= STABLE;
                        r_cnt   <= c_CNT_ZERO;
                    end else begin
                        r_cnt   <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= STABLE;
                    r_cnt   <= c_CNT_ZERO;
                end
            endcase
        end
    end

    assign o_clean  = r_clean;
    assign o_update = w_expire;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : WIDTH-bit switch debouncer with change pulse; optional rising
//               edge capture and irq when SWITCH_EDGE_CAPTURE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH           = c_WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = c_SYNC_STAGES_DEFAULT
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] sw_raw,
`ifdef SWITCH_EDGE_CAPTURE_EN
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq,
`endif
    output logic [WIDTH-1:0] sw_clean,
    output logic             sw_changed
);

    logic [WIDTH-1:0] w_update;
    logic             r_changed;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_bit (
                .clk      (clk_clk),
                .rst      (reset_reset),
                .i_raw    (sw_raw[gi]),
                .o_clean  (sw_clean[gi]),
                .o_update (w_update[gi])
            );
        end
    endgenerate

    // Built from the per-bit update strobes so the pulse lines up with the
    // first cycle the new sw_clean value is visible.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_update;
        end
    end

    assign sw_changed = r_changed;

`ifdef SWITCH_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_cap_next;
    logic [WIDTH-1:0] r_cap;
    logic             r_irq;

    // Set has priority over a same-cycle clear.
    assign w_rise     = w_update & ~sw_clean;
    assign w_cap_next = (r_cap & ~edge_clear) | w_rise;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_cap <= '0;
            r_irq <= 1'b0;
        end else begin
            r_cap <= w_cap_next;
            r_irq <= |w_cap_next;
        end
    end

    assign edge_capture = r_cap;
    assign irq          = r_irq;
`endif

endmodule : switch_debounce
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debounce
// Description : Randomized self-checking bench for switch_debounce
//               (DEBOUNCE_CYCLES 16 and 1 instances) against a window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    localparam int W  = 8;
    localparam int SS = 2;

    logic         clk_clk = 1'b0;
    logic         reset_reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] edge_clear = '0;
    logic [W-1:0] clean16, clean1;
    logic         chg16, chg1;
`ifdef SWITCH_EDGE_CAPTURE_EN
    logic [W-1:0] cap16, cap1;
    logic         irq16, irq1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_clk = ~clk_clk;

    switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(16), .SYNC_STAGES(SS)) u_dut16 (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .sw_raw       (sw_raw),
`ifdef SWITCH_EDGE_CAPTURE_EN
        .edge_clear   (edge_clear),
        .edge_capture (cap16),
        .irq          (irq16),
`endif
        .sw_clean     (clean16),
        .sw_changed   (chg16)
    );

    switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(1), .SYNC_STAGES(SS)) u_dut1 (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .sw_raw       (sw_raw),
`ifdef SWITCH_EDGE_CAPTURE_EN
        .edge_clear   (edge_clear),
        .edge_capture (cap1),
        .irq          (irq1),
`endif
        .sw_clean     (clean1),
        .sw_changed   (chg1)
    );

    // Model: history of raw samples since reset release; a clean bit flips
    // when the last D synchronized samples all disagree with it.
    logic [W-1:0] hist[$];
    int           n = 0;
    logic [W-1:0] m_clean16 = '0, m_clean1 = '0;
    logic         m_chg16 = 1'b0, m_chg1 = 1'b0;
    logic [W-1:0] m_cap16 = '0, m_cap1 = '0;
    logic         m_irq16 = 1'b0, m_irq1 = 1'b0;

    function automatic logic [W-1:0] obs(input int k);
        if (k - SS >= 1) return hist[k-SS-1];
        return '0;
    endfunction

    function automatic logic [W-1:0] next_clean(input logic [W-1:0] cur, input int d);
        logic [W-1:0] res;
        logic         ok;
        logic [W-1:0] o;
        res = cur;
        if (n - d + 1 >= 1) begin
            for (int b = 0; b < W; b++) begin
                ok = 1'b1;
                for (int k = n - d + 1; k <= n; k++) begin
                    o = obs(k);
                    if (o[b] == cur[b]) ok = 1'b0;
                end
                if (ok) res[b] = ~cur[b];
            end
        end
        return res;
    endfunction

    always @(posedge clk_clk) begin
        logic [W-1:0] nc;
        if (reset_reset) begin
            hist.delete();
            n = 0;
            m_clean16 = '0; m_chg16 = 1'b0; m_cap16 = '0; m_irq16 = 1'b0;
            m_clean1  = '0; m_chg1  = 1'b0; m_cap1  = '0; m_irq1  = 1'b0;
        end else begin
            hist.push_back(sw_raw);
            n++;
            nc        = next_clean(m_clean16, 16);
            m_chg16   = (nc != m_clean16);
            m_cap16   = (m_cap16 & ~edge_clear) | (nc & ~m_clean16);
            m_irq16   = |m_cap16;
            m_clean16 = nc;
            nc        = next_clean(m_clean1, 1);
            m_chg1    = (nc != m_clean1);
            m_cap1    = (m_cap1 & ~edge_clear) | (nc & ~m_clean1);
            m_irq1    = |m_cap1;
            m_clean1  = nc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            check("model_clean16", 32'(clean16), 32'(m_clean16));
            check("model_chg16",   32'(chg16),   32'(m_chg16));
            check("model_clean1",  32'(clean1),  32'(m_clean1));
            check("model_chg1",    32'(chg1),    32'(m_chg1));
`ifdef SWITCH_EDGE_CAPTURE_EN
            check("model_cap16", 32'(cap16), 32'(m_cap16));
            check("model_irq16", 32'(irq16), 32'(m_irq16));
            check("model_cap1",  32'(cap1),  32'(m_cap1));
            check("model_irq1",  32'(irq1),  32'(m_irq1));
`endif
        end
    end

    task automatic settle(input logic [W-1:0] v);
        @(negedge clk_clk);
        sw_raw = v;
        repeat (30) @(negedge clk_clk);
    endtask

    initial begin
        int pulses;
        logic held;
        logic [W-1:0] pat;
        int len;

        repeat (3) @(negedge clk_clk);
        check("reset_clean16", 32'(clean16), 32'h0);
        check("reset_chg16",   32'(chg16),   32'h0);
        check("reset_clean1",  32'(clean1),  32'h0);
        #1 reset_reset = 1'b0;
        repeat (3) @(negedge clk_clk);

        // Single bit rise: 18 cycles on D=16, 3 cycles on D=1
        sw_raw = 8'h01;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_clk);
            if (k == 2)  check("lat1_before", 32'(clean1), 32'h00);
            if (k == 3)  check("lat1_at",     32'(clean1), 32'h01);
            if (k == 17) check("lat16_before", 32'(clean16), 32'h00);
            if (k == 18) check("lat16_at",     32'(clean16), 32'h01);
            if (k == 18) check("lat16_pulse",  32'(chg16),   32'h1);
            if (k == 19) check("lat16_pulse_end", 32'(chg16), 32'h0);
        end

        // Bit 3 bounces every 5 cycles for 100 cycles, then holds high
        held = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c % 5 == 0) sw_raw[3] = ~sw_raw[3];
            @(negedge clk_clk);
            if (clean16[3] !== 1'b0) held = 1'b0;
        end
        check("bounce_hold_low", 32'(held), 32'h1);
        sw_raw[3] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk_clk);
            if (k == 17) check("bounce_before", 32'(clean16[3]), 32'h0);
            if (k == 18) check("bounce_rise",   32'(clean16[3]), 32'h1);
        end

        // Random patterns with single-bit noise
        for (int seg = 0; seg < 60; seg++) begin
            pat = 8'($urandom);
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                if ((seg % 2 == 1) && ($urandom_range(0, 3) == 0))
                    sw_raw = pat ^ (8'(1) << $urandom_range(0, 7));
                else
                    sw_raw = pat;
                edge_clear = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
                @(negedge clk_clk);
            end
        end
        edge_clear = 8'h00;

        // All bits rise together: one pulse
        settle(8'h00);
        sw_raw = 8'hFF;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_clk);
            if (chg16) pulses++;
            if (k == 17) check("all_before", 32'(clean16), 32'h00);
            if (k == 18) check("all_at",     32'(clean16), 32'hFF);
        end
        check("all_one_pulse", 32'(pulses), 32'd1);

        // Reset mid-PENDING discards partial count
        settle(8'h00);
        sw_raw = 8'h04;
        repeat (10) @(negedge clk_clk);
        #1 reset_reset = 1'b1;
        repeat (3) @(negedge clk_clk);
        check("midrst_clean", 32'(clean16), 32'h00);
        #1 reset_reset = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk_clk);
            if (k == 17) check("midrst_before", 32'(clean16), 32'h00);
            if (k == 18) check("midrst_at",     32'(clean16), 32'h04);
        end

`ifdef SWITCH_EDGE_CAPTURE_EN
        // Simultaneous set and clear leaves the bit set; next clear drops it
        settle(8'h00);
        edge_clear = 8'hFF;
        @(negedge clk_clk);
        edge_clear = 8'h00;
        sw_raw = 8'h04;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk_clk);
            if (k == 17) edge_clear = 8'h04;
            if (k == 18) begin
                check("cap_set_wins", 32'(cap16), 32'h04);
                check("irq_set",      32'(irq16), 32'h1);
            end
            if (k == 19) begin
                check("cap_cleared", 32'(cap16), 32'h00);
                check("irq_cleared", 32'(irq16), 32'h0);
            end
        end
        edge_clear = 8'h00;
`endif

        // D=1 build with bit 7
        settle(8'h00);
        sw_raw = 8'h80;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_clk);
            if (k == 2) check("d1_before", 32'(clean1), 32'h00);
            if (k == 3) check("d1_at",     32'(clean1), 32'h80);
        end
        repeat (20) @(negedge clk_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_switch_debounce
`default_nettype wire
